// File: rtl/matmul_seq_ctrl.sv
// Sequences operand load (A then B), multiplier kick, timed wait, vblank-aligned display update.
// read_ready one cycle after last B accept; in_valid low stalls loading with no state change.
module matmul_seq_ctrl #(
  parameter int N       = 3,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  input  logic                   compute_done,
  input  logic                   vblank,
  output logic [N*N*WIDTH-1:0]   matrix_a,
  output logic [N*N*WIDTH-1:0]   matrix_b,
  output logic                   read_ready,
  output logic                   disp_update,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int NN = N * N;
  localparam int EW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [EW-1:0] E_LAST = EW'(NN - 1);
  localparam logic [15:0]   W_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_KICK, S_WAIT, S_SYNC, S_DONE, S_ERR
  } state_t;

  state_t                 state_q, state_d;
  logic [EW-1:0]          e_q, e_d;
  logic [15:0]            wcnt_q, wcnt_d;
  logic                   vblank_q;
  logic [NN*WIDTH-1:0]    a_q, a_d, b_q, b_d;
  logic                   loading;
  logic                   vb_rise;

  assign loading = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign vb_rise = vblank && !vblank_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LOAD_A;
      S_LOAD_A: if (in_valid && e_q == E_LAST) state_d = S_LOAD_B;
      S_LOAD_B: if (in_valid && e_q == E_LAST) state_d = S_KICK;
      S_KICK:   state_d = S_WAIT;
      // compute_done takes priority over a coincident timeout
      S_WAIT: begin
        if (compute_done)          state_d = S_SYNC;
        else if (wcnt_q == W_LAST) state_d = S_ERR;
      end
      S_SYNC:   if (vb_rise) state_d = S_DONE;
      S_DONE:   if (start) state_d = S_LOAD_A;
      S_ERR:    if (start) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = loading;
    read_ready  = (state_q == S_KICK);
    disp_update = (state_q == S_SYNC) && vb_rise;
    busy        = loading || (state_q == S_KICK) || (state_q == S_WAIT) || (state_q == S_SYNC);
    done        = (state_q == S_DONE);
    error       = (state_q == S_ERR);
    matrix_a    = a_q;
    matrix_b    = b_q;
  end

  // Element counter rests at zero outside the load states, so every new sequence starts at e=0.
  always_comb begin
    e_d    = '0;
    wcnt_d = '0;
    a_d    = a_q;
    b_d    = b_q;
    if (loading) begin
      e_d = e_q;
      if (in_valid) begin
        if (state_q == S_LOAD_A) a_d[e_q*WIDTH +: WIDTH] = in_data;
        else                     b_d[e_q*WIDTH +: WIDTH] = in_data;
        e_d = (e_q == E_LAST) ? '0 : e_q + EW'(1);
      end
    end
    if (state_q == S_WAIT) wcnt_d = wcnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      e_q      <= '0;
      wcnt_q   <= '0;
      vblank_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      e_q      <= e_d;
      wcnt_q   <= wcnt_d;
      vblank_q <= vblank;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Randomized bench for matmul_seq_ctrl with a transaction-level expectation model.
module tb_matmul_seq_ctrl;

  localparam int N  = 3;
  localparam int W  = 16;
  localparam int TO = 8;
  localparam int NN = N * N;
  localparam int MW = NN * W;

  logic          clk = 1'b0;
  logic          reset, start, in_valid, compute_done, vblank;
  logic [W-1:0]  in_data;
  logic          in_ready, read_ready, disp_update, busy, done, error;
  logic [MW-1:0] matrix_a, matrix_b;

  int            checks = 0;
  int            errors = 0;
  logic          prev_vb = 1'b0;
  logic [W-1:0]  words [2*NN];
  logic [MW-1:0] exp_a, exp_b;

  matmul_seq_ctrl #(.N(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .compute_done(compute_done), .vblank(vblank),
    .matrix_a(matrix_a), .matrix_b(matrix_b), .read_ready(read_ready),
    .disp_update(disp_update), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected flags packed as {busy, done, error, in_ready, read_ready, disp_update}
  task automatic chk_flags(input string tag, input logic [5:0] exp);
    check(tag, MW'({busy, done, error, in_ready, read_ready, disp_update}), MW'(exp));
  endtask

  // Advance to just after the next edge and record the vblank value the DUT registered there.
  task automatic tick();
    @(posedge clk);
    prev_vb = reset ? vblank : 1'b0;
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset(input int ncyc);
    tick();
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    compute_done = 1'($urandom); vblank = 1'($urandom);
    settle();
    for (int i = 0; i < ncyc; i++) begin
      tick(); settle();
      chk_flags("rst_flags", 6'b000000);
      check("rst_a", matrix_a, '0);
      check("rst_b", matrix_b, '0);
    end
    tick();
    reset = 1'b1;
    settle();
    chk_flags("rst_release", 6'b000000);
    tick(); settle();
    chk_flags("idle_after_rst", 6'b000000);
  endtask

  // vmode: 0 valid held, 1 valid toggled, 2 random; cd: WAIT cycle index of compute_done;
  // vbmode 1 keeps vblank high into SYNC, then low 3 cycles, then rising.
  task automatic run_seq(input int vmode, input int cd, input int vbmode,
                         input bit hold, input bit dir_data);
    int  k;
    bit  found, a_seen;
    logic exp_du;
    for (int i = 0; i < 2*NN; i++) begin
      words[i] = dir_data ? W'(i + 1) : W'($urandom);
      if (i < NN) exp_a[i*W +: W] = words[i];
      else        exp_b[(i-NN)*W +: W] = words[i];
    end
    tick();
    start = 1'b1; in_valid = 1'b0; compute_done = 1'b0; vblank = 1'($urandom);
    settle();
    k = 0; a_seen = 1'b0;
    for (int cyc = 0; k < 2*NN && cyc < 300; cyc++) begin
      tick();
      start = hold;
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      in_data = words[k];
      compute_done = 1'($urandom);
      vblank = 1'($urandom);
      settle();
      chk_flags("load_flags", 6'b100100);
      if (k == NN && !a_seen) begin
        check("a_during_load_b", matrix_a, exp_a);
        a_seen = 1'b1;
      end
      if (in_valid) k++;
    end
    check("words_accepted", MW'(k), MW'(2*NN));
    tick();
    start = hold; in_valid = 1'($urandom); compute_done = 1'($urandom); vblank = 1'($urandom);
    settle();
    chk_flags("kick_flags", 6'b100010);
    check("kick_a", matrix_a, exp_a);
    check("kick_b", matrix_b, exp_b);
    for (int i = 0; i < TO; i++) begin
      tick();
      start = hold; in_valid = 1'($urandom);
      compute_done = (i == cd);
      vblank = (vbmode == 1) ? 1'b1 : 1'($urandom);
      settle();
      chk_flags("wait_flags", 6'b100000);
      if (compute_done) break;
    end
    if (cd >= TO) begin
      tick();
      start = 1'b0; compute_done = 1'b1; vblank = 1'($urandom);
      settle();
      chk_flags("timeout_err", 6'b001000);
      check("err_a", matrix_a, exp_a);
      check("err_b", matrix_b, exp_b);
      tick(); start = 1'b1; settle();
      chk_flags("err_hold", 6'b001000);
      tick(); start = 1'b0; settle();
      chk_flags("err_to_idle", 6'b000000);
      return;
    end
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      tick();
      start = hold; compute_done = 1'($urandom); in_valid = 1'($urandom);
      if (vbmode == 1)  vblank = (i < 2 || i >= 5);
      else if (i >= 40) vblank = ~prev_vb;
      else              vblank = 1'($urandom);
      settle();
      exp_du = vblank & ~prev_vb;
      chk_flags("sync_flags", {5'b10000, exp_du});
      if (exp_du) begin
        found = 1'b1;
        if (vbmode == 1) check("sync_edge_pos", MW'(i), MW'(5));
      end
    end
    if (!found) check("sync_timeout", MW'(0), MW'(1));
    tick();
    start = hold; compute_done = 1'($urandom); vblank = 1'($urandom);
    settle();
    chk_flags("done_flags", 6'b010000);
    check("done_a", matrix_a, exp_a);
    check("done_b", matrix_b, exp_b);
    if (hold) begin
      tick();
      start = 1'b0; in_valid = 1'b0;
      settle();
      chk_flags("restart_load_a", 6'b100100);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    compute_done = 1'b0; vblank = 1'b0;
    exp_a = '0; exp_b = '0;
    do_reset(2);

    run_seq(0, 4, 0, 1'b0, 1'b1);
    check("a_elem0", MW'(matrix_a[0 +: W]), MW'(1));
    check("a_elem8", MW'(matrix_a[8*W +: W]), MW'(9));
    check("b_elem0", MW'(matrix_b[0 +: W]), MW'(10));
    check("b_elem8", MW'(matrix_b[8*W +: W]), MW'(18));

    run_seq(1, 2, 0, 1'b0, 1'b1);
    run_seq(0, TO + 1, 0, 1'b0, 1'b0);
    run_seq(2, TO - 1, 1, 1'b0, 1'b0);
    run_seq(2, 3, 1, 1'b0, 1'b0);

    // Abort a load after four A words.
    tick(); start = 1'b1; in_valid = 1'b0; settle();
    for (int i = 0; i < 4; i++) begin
      tick(); start = 1'b0; in_valid = 1'b1; in_data = W'($urandom); settle();
      chk_flags("partial_load", 6'b100100);
    end
    do_reset(2);
    run_seq(2, int'($urandom_range(0, TO - 1)), 0, 1'b0, 1'b0);

    run_seq(0, 1, 0, 1'b1, 1'b0);
    do_reset(1);

    for (int r = 0; r < 12; r++) begin
      run_seq(int'($urandom_range(0, 2)), int'($urandom_range(0, TO + 2)),
              int'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
